// File: rtl/kudu_perf_ctrl_if.sv
// Command and dump-stream port bundle for kudu_perf_ctrl.
// slave = the controller, master = the command issuer / dump consumer.
interface kudu_perf_ctrl_if #(
  parameter int NUM_EVT = 16,
  parameter int CNT_W   = 32
);
  localparam int IDX_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;

  logic             cmd_valid_i;
  logic [1:0]       cmd_op_i;
  logic             cmd_ready_o;
  logic             dump_valid_o;
  logic             dump_ready_i;
  logic [IDX_W-1:0] dump_idx_o;
  logic [CNT_W-1:0] dump_data_o;
  logic             dump_ovf_o;
  logic             dump_last_o;

  modport slave (
    input  cmd_valid_i, cmd_op_i, dump_ready_i,
    output cmd_ready_o, dump_valid_o, dump_idx_o, dump_data_o, dump_ovf_o, dump_last_o
  );

  modport master (
    output cmd_valid_i, cmd_op_i, dump_ready_i,
    input  cmd_ready_o, dump_valid_o, dump_idx_o, dump_data_o, dump_ovf_o, dump_last_o
  );
endinterface

// File: rtl/kudu_perf_ctrl.sv
// Performance-counter bank with start/stop/clear/dump command sequencing.
// Define KUDU_PERF_SAT_EN for saturating counters; default build wraps.
module kudu_perf_ctrl #(
  parameter int NUM_EVT = 16,
  parameter int CNT_W   = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_EVT-1:0]  evt_i,
  kudu_perf_ctrl_if.slave     bus,
  output logic                running_o,
  output logic [NUM_EVT-1:0]  ovf_o
);
  localparam int IDX_W = (NUM_EVT > 1) ? $clog2(NUM_EVT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EVT - 1);

  typedef enum logic {
    ST_IDLE,
    ST_DUMP
  } state_e;

  typedef enum logic [1:0] {
    OP_START = 2'd0,
    OP_STOP  = 2'd1,
    OP_CLEAR = 2'd2,
    OP_DUMP  = 2'd3
  } op_e;

  state_e                          state_q;
  logic                            run_q;
  logic                            cmd_ready_q;
  logic                            dump_valid_q;
  logic [IDX_W-1:0]                idx_q;
  logic [NUM_EVT-1:0][CNT_W-1:0]   cnt_q, cnt_inc, cnt_nxt;
  logic [NUM_EVT-1:0][CNT_W-1:0]   shd_q;
  logic [NUM_EVT-1:0]              ovf_q, ovf_inc, ovf_nxt;
  logic [NUM_EVT-1:0]              shd_ovf_q;
  logic                            cmd_fire;
  op_e                             op;

  // cmd_ready_q is only ever high in IDLE, so it doubles as the state qualifier.
  assign cmd_fire = bus.cmd_valid_i & cmd_ready_q;
  assign op       = op_e'(bus.cmd_op_i);

  always_comb begin
    cnt_inc = cnt_q;
    ovf_inc = ovf_q;
    for (int unsigned i = 0; i < NUM_EVT; i++) begin
      if (run_q && evt_i[i]) begin
        if (&cnt_q[i]) begin
          ovf_inc[i] = 1'b1;
`ifdef KUDU_PERF_SAT_EN
          cnt_inc[i] = cnt_q[i];
`else
          cnt_inc[i] = '0;
`endif
        end else begin
          cnt_inc[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // CLEAR discards any increment landing in its accept cycle.
  always_comb begin
    cnt_nxt = cnt_inc;
    ovf_nxt = ovf_inc;
    if (cmd_fire && op == OP_CLEAR) begin
      cnt_nxt = '0;
      ovf_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      run_q        <= 1'b0;
      cmd_ready_q  <= 1'b1;
      dump_valid_q <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= '0;
      shd_q        <= '0;
      shd_ovf_q    <= '0;
    end else begin
      cnt_q <= cnt_nxt;
      ovf_q <= ovf_nxt;
      case (state_q)
        ST_IDLE: begin
          if (cmd_fire) begin
            case (op)
              OP_START: run_q <= 1'b1;
              OP_STOP:  run_q <= 1'b0;
              OP_DUMP: begin
                shd_q        <= cnt_inc;
                shd_ovf_q    <= ovf_inc;
                idx_q        <= '0;
                state_q      <= ST_DUMP;
                cmd_ready_q  <= 1'b0;
                dump_valid_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        ST_DUMP: begin
          if (bus.dump_ready_i) begin
            if (idx_q == LAST_IDX) begin
              idx_q        <= '0;
              state_q      <= ST_IDLE;
              cmd_ready_q  <= 1'b1;
              dump_valid_q <= 1'b0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          cmd_ready_q  <= 1'b1;
          dump_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready_o  = cmd_ready_q;
  assign bus.dump_valid_o = dump_valid_q;
  assign bus.dump_idx_o   = idx_q;
  assign bus.dump_data_o  = shd_q[idx_q];
  assign bus.dump_ovf_o   = shd_ovf_q[idx_q];
  assign bus.dump_last_o  = dump_valid_q & (idx_q == LAST_IDX);
  assign running_o        = run_q;
  assign ovf_o            = ovf_q;
endmodule

// File: tb/tb_kudu_perf_ctrl.sv
// Scoreboard bench for kudu_perf_ctrl: 16x32 main instance plus a 4x8 instance for overflow.
module tb_kudu_perf_ctrl;
  localparam int N  = 16;
  localparam int W  = 32;
  localparam int SN = 4;
  localparam int SW = 8;
  localparam logic [1:0] C_START = 2'd0, C_STOP = 2'd1, C_CLEAR = 2'd2, C_DUMP = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]  evt;
  logic          running;
  logic [N-1:0]  ovf;
  logic [SN-1:0] sevt;
  logic          srunning;
  logic [SN-1:0] sovf;

  kudu_perf_ctrl_if #(.NUM_EVT(N), .CNT_W(W)) bus ();
  kudu_perf_ctrl_if #(.NUM_EVT(SN), .CNT_W(SW)) sbus ();

  kudu_perf_ctrl #(.NUM_EVT(N), .CNT_W(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .evt_i(evt), .bus(bus),
    .running_o(running), .ovf_o(ovf)
  );

  kudu_perf_ctrl #(.NUM_EVT(SN), .CNT_W(SW)) sdut (
    .clk_i(clk), .rst_ni(rst_n), .evt_i(sevt), .bus(sbus),
    .running_o(srunning), .ovf_o(sovf)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int unsigned   idx;
    logic [W-1:0]  data;
    logic          ovf;
    logic          last;
  } entry_t;

  entry_t sb[$];
  entry_t exp_e;

  logic         stall_prev = 1'b0;
  logic [3:0]   s_idx;
  logic [W-1:0] s_data;
  logic         s_ovf, s_last;

  // Dump-stream consumer: sampled on the falling edge, between input updates.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if ({bus.dump_idx_o, bus.dump_data_o, bus.dump_ovf_o, bus.dump_last_o} !==
            {s_idx, s_data, s_ovf, s_last}) begin
          errors++;
          $display("FAIL stall_hold actual idx=%0d data=%0d ovf=%b last=%b required idx=%0d data=%0d ovf=%b last=%b",
                   bus.dump_idx_o, bus.dump_data_o, bus.dump_ovf_o, bus.dump_last_o,
                   s_idx, s_data, s_ovf, s_last);
        end
      end
      stall_prev = bus.dump_valid_o & ~bus.dump_ready_i;
      s_idx  = bus.dump_idx_o;
      s_data = bus.dump_data_o;
      s_ovf  = bus.dump_ovf_o;
      s_last = bus.dump_last_o;
      if (bus.dump_valid_o === 1'b1 && bus.dump_ready_i === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL dump_unexpected actual idx=%0d required no entry", bus.dump_idx_o);
        end else begin
          exp_e = sb.pop_front();
          if (bus.dump_idx_o !== 4'(exp_e.idx) || bus.dump_data_o !== exp_e.data ||
              bus.dump_ovf_o !== exp_e.ovf || bus.dump_last_o !== exp_e.last) begin
            errors++;
            $display("FAIL dump_entry actual idx=%0d data=%0d ovf=%b last=%b required idx=%0d data=%0d ovf=%b last=%b",
                     bus.dump_idx_o, bus.dump_data_o, bus.dump_ovf_o, bus.dump_last_o,
                     exp_e.idx, exp_e.data, exp_e.ovf, exp_e.last);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input int unsigned idx, input logic [W-1:0] data);
    sb.push_back('{idx: idx, data: data, ovf: 1'b0, last: (idx == N - 1)});
  endtask

  task automatic do_cmd(input logic [1:0] op);
    bus.cmd_op_i    = op;
    bus.cmd_valid_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      if (bus.cmd_ready_o === 1'b1) begin
        tick();
        bus.cmd_valid_i = 1'b0;
        return;
      end
      tick();
    end
    checks++;
    errors++;
    $display("FAIL cmd_accept op=%0d actual=not accepted required=accepted", op);
    bus.cmd_valid_i = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 200; c++) begin
      if (bus.cmd_ready_o === 1'b1) return;
      tick();
    end
    checks++;
    errors++;
    $display("FAIL %s_idle_timeout actual cmd_ready=0 required cmd_ready=1", name);
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if (bus.cmd_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready actual=%b required=1", bus.cmd_ready_o);
    end
    checks++;
    if ({bus.dump_valid_o, bus.dump_ovf_o, bus.dump_last_o} !== 3'b000) begin
      errors++; $display("FAIL reset_dump_flags actual=%b required=000",
                         {bus.dump_valid_o, bus.dump_ovf_o, bus.dump_last_o});
    end
    checks++;
    if (bus.dump_idx_o !== 4'd0 || bus.dump_data_o !== '0) begin
      errors++; $display("FAIL reset_dump_bus actual idx=%0d data=%0d required 0 0",
                         bus.dump_idx_o, bus.dump_data_o);
    end
    checks++;
    if (running !== 1'b0 || ovf !== '0 || srunning !== 1'b0 || sovf !== '0) begin
      errors++; $display("FAIL reset_run_ovf actual run=%b ovf=%h required 0 0", running, ovf);
    end
  endtask

  task automatic test_basic();
    bus.dump_ready_i = 1'b1;
    evt = 16'h0008;
    do_cmd(C_START);
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL basic_running actual=%b required=1", running);
    end
    repeat (10) tick();
    evt = '0;
    do_cmd(C_STOP);
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL basic_stopped actual=%b required=0", running);
    end
    evt = 16'h0008;
    repeat (5) tick();
    evt = '0;
    for (int unsigned i = 0; i < N; i++) push_entry(i, (i == 3) ? W'(10) : '0);
    do_cmd(C_DUMP);
    wait_idle("basic");
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL basic_drain actual left=%0d required=0", sb.size());
    end
  endtask

  task automatic test_clear_event();
    do_cmd(C_CLEAR);
    do_cmd(C_START);
    evt = 16'h0001;
    repeat (7) tick();
    do_cmd(C_CLEAR);
    evt = '0;
    checks++;
    if (ovf !== '0 || running !== 1'b1) begin
      errors++; $display("FAIL clear_state actual ovf=%h run=%b required ovf=0 run=1", ovf, running);
    end
    do_cmd(C_STOP);
    for (int unsigned i = 0; i < N; i++) push_entry(i, '0);
    do_cmd(C_DUMP);
    wait_idle("clear");
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL clear_drain actual left=%0d required=0", sb.size());
    end
  endtask

  task automatic test_snapshot();
    int k;
    do_cmd(C_CLEAR);
    do_cmd(C_START);
    evt = '1;
    repeat (20) tick();
    for (int unsigned i = 0; i < N; i++) push_entry(i, W'(21));
    bus.dump_ready_i = 1'b0;
    do_cmd(C_DUMP);
    k = 0;
    for (int c = 0; c < 200; c++) begin
      bus.dump_ready_i = k[0];
      tick();
      k++;
      if (bus.cmd_ready_o === 1'b1) break;
    end
    evt = '0;
    bus.dump_ready_i = 1'b1;
    checks++;
    if (k != 32) begin
      errors++; $display("FAIL snap_length actual=%0d required=32", k);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL snap_drain actual left=%0d required=0", sb.size());
    end
    do_cmd(C_STOP);
    for (int unsigned i = 0; i < N; i++) push_entry(i, W'(21 + k));
    do_cmd(C_DUMP);
    wait_idle("live");
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL live_drain actual left=%0d required=0", sb.size());
    end
  endtask

  task automatic test_overflow();
    logic         seen;
    logic [SW-1:0] got_data;
    logic          got_ovf;
    logic [SW-1:0] want;
`ifdef KUDU_PERF_SAT_EN
    want = 8'd255;
`else
    want = 8'd1;
`endif
    sbus.dump_ready_i = 1'b1;
    sbus.cmd_op_i     = C_START;
    sbus.cmd_valid_i  = 1'b1;
    tick();
    sbus.cmd_valid_i  = 1'b0;
    sevt = 4'b0010;
    repeat (255) tick();
    checks++;
    if (sovf !== 4'b0000) begin
      errors++; $display("FAIL ovf_at_255 actual=%b required=0000", sovf);
    end
    repeat (2) tick();
    sevt = '0;
    checks++;
    if (sovf !== 4'b0010) begin
      errors++; $display("FAIL ovf_flag actual=%b required=0010", sovf);
    end
    sbus.cmd_op_i    = C_DUMP;
    sbus.cmd_valid_i = 1'b1;
    tick();
    sbus.cmd_valid_i = 1'b0;
    seen = 1'b0;
    got_data = '0;
    got_ovf  = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sbus.dump_valid_o === 1'b1 && sbus.dump_idx_o === 2'd1) begin
        seen = 1'b1;
        got_data = sbus.dump_data_o;
        got_ovf  = sbus.dump_ovf_o;
      end
      if (sbus.cmd_ready_o === 1'b1) break;
      tick();
    end
    checks++;
    if (!seen || got_data !== want || got_ovf !== 1'b1) begin
      errors++; $display("FAIL ovf_entry actual seen=%b data=%0d ovf=%b required seen=1 data=%0d ovf=1",
                         seen, got_data, got_ovf, want);
    end
  endtask

  task automatic test_back_pressure();
    int nlow;
    do_cmd(C_CLEAR);
    do_cmd(C_START);
    for (int unsigned i = 0; i < N; i++) push_entry(i, '0);
    bus.dump_ready_i = 1'b1;
    do_cmd(C_DUMP);
    bus.cmd_op_i    = C_STOP;
    bus.cmd_valid_i = 1'b1;
    nlow = 0;
    for (int c = 0; c < 100; c++) begin
      if (bus.cmd_ready_o === 1'b1) break;
      nlow++;
      tick();
    end
    checks++;
    if (running !== 1'b1) begin
      errors++; $display("FAIL bp_held_running actual=%b required=1", running);
    end
    tick();
    bus.cmd_valid_i = 1'b0;
    checks++;
    if (nlow != 16) begin
      errors++; $display("FAIL bp_ready_low actual=%0d required=16", nlow);
    end
    checks++;
    if (running !== 1'b0) begin
      errors++; $display("FAIL bp_stop_accept actual=%b required=0", running);
    end
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL bp_drain actual left=%0d required=0", sb.size());
    end
  endtask

  task automatic test_reset_mid_dump();
    logic hit;
    do_cmd(C_START);
    evt = 16'h0004;
    repeat (3) tick();
    evt = '0;
    do_cmd(C_STOP);
    for (int unsigned i = 0; i < N; i++) push_entry(i, (i == 2) ? W'(3) : '0);
    bus.dump_ready_i = 1'b1;
    do_cmd(C_DUMP);
    hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (bus.dump_idx_o === 4'd5) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (!hit || sb.size() != 11) begin
      errors++; $display("FAIL rstmid_progress actual hit=%b left=%0d required hit=1 left=11", hit, sb.size());
    end
    sb.delete();
    checks++;
    if (bus.cmd_ready_o !== 1'b1 || bus.dump_valid_o !== 1'b0 || bus.dump_idx_o !== 4'd0 ||
        bus.dump_data_o !== '0 || bus.dump_ovf_o !== 1'b0 || bus.dump_last_o !== 1'b0 ||
        running !== 1'b0 || ovf !== '0) begin
      errors++; $display("FAIL rstmid_values actual rdy=%b vld=%b idx=%0d data=%0d last=%b required 1 0 0 0 0",
                         bus.cmd_ready_o, bus.dump_valid_o, bus.dump_idx_o, bus.dump_data_o, bus.dump_last_o);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.cmd_ready_o !== 1'b1 || bus.dump_valid_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_release actual rdy=%b vld=%b required 1 0", bus.cmd_ready_o, bus.dump_valid_o);
    end
    repeat (5) tick();
    checks++;
    if (bus.dump_valid_o !== 1'b0) begin
      errors++; $display("FAIL rstmid_no_stream actual=%b required=0", bus.dump_valid_o);
    end
    for (int unsigned i = 0; i < N; i++) push_entry(i, '0);
    do_cmd(C_DUMP);
    wait_idle("rstmid");
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL rstmid_drain actual left=%0d required=0", sb.size());
    end
  endtask

  initial begin
    evt = '0;
    sevt = '0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_op_i = 2'd0;
    bus.dump_ready_i = 1'b0;
    sbus.cmd_valid_i = 1'b0;
    sbus.cmd_op_i = 2'd0;
    sbus.dump_ready_i = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset();
    test_basic();
    test_clear_event();
    test_snapshot();
    test_overflow();
    test_back_pressure();
    test_reset_mid_dump();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/kudu_perf_ctrl.md
# kudu_perf_ctrl

Performance-counter controller for the Kudu simulation and debug infrastructure. It owns a bank of `NUM_EVT` event counters fed by single-cycle event strobes from the issuer and pipeline, such as issue, hazard and mispredict events. It sequences start, stop, clear and dump commands arriving over a valid/ready command port. A dump snapshots the whole bank into shadow registers, then streams it out one entry per handshake while live counting continues.

## Interface

Parameters:
- `NUM_EVT`, default 16: number of event inputs and counters; legal range 2..64.
- `CNT_W`, default 32: counter width in bits; legal range 8..64.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `evt_i`  in  NUM_EVT  event strobes; bit i high means counter i gets +1 this cycle.
- `cmd_valid_i`  in  1  command request.
- `cmd_op_i`  in  2  command code: 0 START, 1 STOP, 2 CLEAR, 3 DUMP.
- `cmd_ready_o`  out  1  command accept; high only in IDLE.
- `dump_valid_o`  out  1  dump entry valid.
- `dump_ready_i`  in  1  dump entry accept.
- `dump_idx_o`  out  $clog2(NUM_EVT)  counter index of the current entry.
- `dump_data_o`  out  CNT_W  snapshot value of the current entry.
- `dump_ovf_o`  out  1  snapshot overflow flag of the current entry.
- `dump_last_o`  out  1  current entry is index NUM_EVT-1.
- `running_o`  out  1  counting enabled.
- `ovf_o`  out  NUM_EVT  live sticky overflow flags.

## Operation

- FSM states:
  - IDLE: `cmd_ready_o`=1.
  - DUMP: `cmd_ready_o`=0, `dump_valid_o`=1.
- A command is accepted on a cycle with `cmd_valid_i & cmd_ready_o`.
- START: sets `run_q`. START while already running is a no-op.
- STOP: clears `run_q`. STOP while already stopped is a no-op.
- CLEAR: zeroes all counters and `ovf_o` on the next edge. `run_q` is unchanged. Any event in the accept cycle is discarded.
- DUMP: on the next edge, the shadow bank captures each counter's next value, including that cycle's increment, together with each ovf flag. The FSM then enters DUMP with the index at 0.
- In DUMP, each `dump_valid_o & dump_ready_i` handshake advances the index by 1.
- The handshake at index NUM_EVT-1 (`dump_last_o`=1) returns the FSM to IDLE on the next edge.
- Counters keep counting during DUMP when `run_q`=1. Live values never disturb the shadow bank.
- Counter i increments on a cycle where `run_q & evt_i[i]`. Multiple counters may increment in the same cycle.
- Overflow: an increment while the counter is all-ones sets `ovf_o[i]`. The flag stays set until CLEAR or reset. Counter behaviour at overflow is set by the configuration macro (see Configuration).
- `dump_idx_o`, `dump_data_o`, `dump_ovf_o` and `dump_last_o` hold stable while `dump_valid_o & ~dump_ready_i`.

## Timing

- Reset values:
  - `cmd_ready_o`=1, `dump_valid_o`=0, `dump_idx_o`=0, `dump_data_o`=0.
  - `dump_ovf_o`=0, `dump_last_o`=0, `running_o`=0, `ovf_o`=0.
  - All counters and shadows = 0. FSM = IDLE.
- START accepted at cycle t: `running_o`=1 at t+1. Events are counted from t+1; the event at t is not counted.
- STOP accepted at cycle t: the event at t is counted. `running_o`=0 at t+1 and nothing is counted from t+1.
- CLEAR accepted at t: all counters read 0 at t+1.
- DUMP accepted at t: `dump_valid_o`=1 with index 0 at t+1.
  - Minimum dump length is NUM_EVT cycles with `dump_ready_i` tied high.
  - `cmd_ready_o` returns to 1 the cycle after the last handshake.
- `cmd_valid_i` asserted during DUMP is held off, not dropped. The command is accepted on the first IDLE cycle.
- Asserting reset mid-dump returns the FSM to IDLE and restores all reset values immediately. No partial stream continues after reset release.

## Configuration

- `KUDU_PERF_SAT_EN` defined: counters saturate at all-ones; further increments leave the value at all-ones.
- `KUDU_PERF_SAT_EN` undefined: counters wrap modulo 2^CNT_W.
- `ovf_o` behaviour is identical in both builds.

## Test plan

- Basic counting:
  - Stimulus: START, then pulse `evt_i[3]` for 10 cycles; STOP; pulse `evt_i[3]` 5 more cycles; DUMP.
  - Response: entry 3 = 10, all other entries = 0.
  - Also check the event in the START accept cycle is not counted.
- Simultaneous CLEAR and event:
  - Stimulus: running with counter 0 = 7; CLEAR accepted in the same cycle as `evt_i[0]`=1.
  - Response: counter 0 reads 0 at the next edge and `ovf_o`=0.
- Snapshot isolation:
  - Stimulus: running with `evt_i`=all-ones; DUMP accepted with all counters = 20; `dump_ready_i` toggled every other cycle.
  - Response: all 16 entries show 21; indices 0..15 are in order; `dump_last_o` only on index 15; outputs stable while stalled.
- Overflow, CNT_W=8:
  - Stimulus: 257 events on counter 1.
  - Response without `KUDU_PERF_SAT_EN`: value 1, `ovf_o[1]`=1.
  - Response with the macro: value 255, `ovf_o[1]`=1.
- Command back-pressure:
  - Stimulus: STOP asserted during DUMP with `dump_ready_i` high.
  - Response: `cmd_ready_o`=0 for 16 cycles; STOP accepted the cycle after the last handshake.
- Reset mid-dump:
  - Stimulus: assert `rst_ni` low at index 5 of a dump.
  - Response: all outputs return to reset values; `cmd_ready_o`=1 after reset release.
